// File: rtl/wsp_pkg.sv
// Shared encodings for the IEEE 1500 wrapper serial port initiator.
package wsp_pkg;
    localparam int WIR_LEN_D = 3;
    localparam int DR_MAX_D  = 20;
    localparam int LEN_W_D   = 5;

    localparam logic [1:0] OP_WRESET   = 2'd0;
    localparam logic [1:0] OP_LOAD_WIR = 2'd1;
    localparam logic [1:0] OP_SCAN_DR  = 2'd2;
    localparam logic [1:0] OP_RSVD     = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_WRST, S_CAPT, S_SHIFT, S_UPD, S_DONE
    } state_t;
endpackage

// File: rtl/wsp_if.sv
// Sequencer command/response channel plus the wrapper serial port pins.
interface wsp_if #(parameter int DR_MAX = 20, parameter int LEN_W = 5);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [LEN_W-1:0]  cmd_len;
    logic [DR_MAX-1:0] cmd_data;
    logic              rsp_valid;
    logic [DR_MAX-1:0] rsp_data;
    logic              WRSTN;
    logic              SelectWIR;
    logic              CaptureWR;
    logic              ShiftWR;
    logic              UpdateWR;
    logic              WSI;
    logic              WSO;

    modport master (
        input  cmd_valid, cmd_op, cmd_len, cmd_data, WSO,
        output cmd_ready, rsp_valid, rsp_data,
               WRSTN, SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI
    );
    modport slave (
        output cmd_valid, cmd_op, cmd_len, cmd_data, WSO,
        input  cmd_ready, rsp_valid, rsp_data,
               WRSTN, SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI
    );
endinterface

// File: rtl/wsp_shift_reg.sv
// Holds the shift-in data and collects WSO bits; the FSM supplies bit positions.
module wsp_shift_reg #(
    parameter int DR_MAX = 20,
    parameter int LEN_W  = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [DR_MAX-1:0] i_data,
    input  logic              i_cap_en,
    input  logic [LEN_W-1:0]  i_cap_idx,
    input  logic              i_wso,
    input  logic [LEN_W-1:0]  i_out_idx,
    output logic              o_bit,
    output logic [DR_MAX-1:0] o_cap
);
    logic [DR_MAX-1:0] r_data;
    logic [DR_MAX-1:0] r_cap;

    // Capture buffer clears on load so bits beyond the scan length read as 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data <= '0;
            r_cap  <= '0;
        end else if (i_load) begin
            r_data <= i_data;
            r_cap  <= '0;
        end else if (i_cap_en) begin
            r_cap[i_cap_idx] <= i_wso;
        end
    end

    assign o_bit = r_data[i_out_idx];
    assign o_cap = r_cap;
endmodule

// File: rtl/wsp_master.sv
// WSP initiator: turns sequencer commands into WSC/WSI sequences and gathers WSO.
module wsp_master
    import wsp_pkg::*;
#(
    parameter int WIR_LEN = WIR_LEN_D,
    parameter int DR_MAX  = DR_MAX_D,
    parameter int LEN_W   = LEN_W_D
) (
    input logic   CK,
    input logic   RST,
    wsp_if.master bus
);
    state_t            r_state, w_state_nxt;
    logic [1:0]        r_op, w_op_nxt;
    logic [LEN_W-1:0]  r_len, w_len_nxt, r_cnt, w_cnt_nxt, w_len_eff;
    logic              w_accept, w_load, w_cap_en, w_bit, w_wsc;
    logic [DR_MAX-1:0] w_cap;
    logic              r_cmd_ready, r_rsp_valid, r_wrstn, r_sel, r_capt, r_shift, r_upd, r_wsi;
    logic [DR_MAX-1:0] r_rsp_data;

    assign w_accept = (r_state == S_IDLE) && r_cmd_ready && bus.cmd_valid;

    always_comb begin
        w_len_eff = '0;
        case (bus.cmd_op)
            OP_LOAD_WIR: w_len_eff = LEN_W'(WIR_LEN);
            OP_SCAN_DR:  w_len_eff = (bus.cmd_len > LEN_W'(DR_MAX)) ? LEN_W'(DR_MAX) : bus.cmd_len;
            default:     w_len_eff = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_cap_en    = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) begin
                w_load      = 1'b1;
                w_op_nxt    = bus.cmd_op;
                w_len_nxt   = w_len_eff;
                w_cnt_nxt   = '0;
                w_state_nxt = (bus.cmd_op == OP_WRESET) ? S_WRST : S_CAPT;
            end
            S_WRST: begin
                if (r_cnt == LEN_W'(1)) w_state_nxt = S_DONE;
                else                    w_cnt_nxt   = r_cnt + LEN_W'(1);
            end
            S_CAPT: begin
                w_cnt_nxt   = '0;
                w_state_nxt = (r_len == '0) ? S_UPD : S_SHIFT;
            end
            S_SHIFT: begin
                // WSO for bit r_cnt is taken at the edge closing this shift cycle.
                w_cap_en = 1'b1;
                if (r_cnt == r_len - LEN_W'(1)) w_state_nxt = S_UPD;
                else                            w_cnt_nxt   = r_cnt + LEN_W'(1);
            end
            S_UPD:   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_wsc = w_state_nxt inside {S_CAPT, S_SHIFT, S_UPD};

    // Outputs are decoded from the next state so every pin comes straight off a flop.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_op        <= OP_WRESET;
            r_len       <= '0;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_wrstn     <= 1'b0;
            r_sel       <= 1'b0;
            r_capt      <= 1'b0;
            r_shift     <= 1'b0;
            r_upd       <= 1'b0;
            r_wsi       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_len       <= w_len_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_rsp_valid <= (w_state_nxt == S_DONE);
            r_wrstn     <= (w_state_nxt != S_WRST);
            r_sel       <= w_wsc && (w_op_nxt == OP_LOAD_WIR);
            r_capt      <= (w_state_nxt == S_CAPT);
            r_shift     <= (w_state_nxt == S_SHIFT);
            r_upd       <= (w_state_nxt == S_UPD);
            r_wsi       <= (w_state_nxt == S_SHIFT) && w_bit;
            if (w_state_nxt == S_DONE) r_rsp_data <= w_cap;
        end
    end

    wsp_shift_reg #(.DR_MAX(DR_MAX), .LEN_W(LEN_W)) u_sr (
        .i_clk     (CK),
        .i_rst     (RST),
        .i_load    (w_load),
        .i_data    (bus.cmd_data),
        .i_cap_en  (w_cap_en),
        .i_cap_idx (r_cnt),
        .i_wso     (bus.WSO),
        .i_out_idx (w_cnt_nxt),
        .o_bit     (w_bit),
        .o_cap     (w_cap)
    );

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.WRSTN     = r_wrstn;
    assign bus.SelectWIR = r_sel;
    assign bus.CaptureWR = r_capt;
    assign bus.ShiftWR   = r_shift;
    assign bus.UpdateWR  = r_upd;
    assign bus.WSI       = r_wsi;
endmodule
